// File: rtl/prio_encoder_rr.sv
// N-to-log2(N) priority encoder with fixed or round-robin arbitration and a
// single registered valid/ready output stage (1-cycle latency, full throughput).
module prio_encoder_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         rr_mode_i,
  output logic [W-1:0] out_idx_o,
  output logic [N-1:0] out_onehot_o,
  output logic         out_any_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic         any_q, any_d;
  logic         valid_q, valid_d;

  logic [W-1:0] fix_idx, rr_idx, win_idx;
  logic         req_any, accept;

  assign req_any    = |req_i;
  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) fix_idx = W'(i);
    end
  end

  // Walk offsets from farthest to nearest so the bit closest to ptr wins.
  always_comb begin
    rr_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) rr_idx = W'(j);
    end
  end

  assign win_idx = !req_any ? '0 : (rr_mode_i ? rr_idx : fix_idx);

  always_comb begin
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    any_d    = any_q;
    valid_d  = valid_q;
    if (accept) begin
      idx_d    = win_idx;
      onehot_d = req_any ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
      any_d    = req_any;
      valid_d  = 1'b1;
      if (rr_mode_i && req_any) begin
        ptr_d = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
      end
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      any_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      any_q    <= any_d;
      valid_q  <= valid_d;
    end
  end

  assign out_idx_o    = idx_q;
  assign out_onehot_o = onehot_q;
  assign out_any_o    = any_q;
  assign out_valid_o  = valid_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed, table-driven bench for prio_encoder_rr (N=8) plus hand-written
// sequences for reset, backpressure and mid-stream reset.
module tb_prio_encoder_rr;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk, rst;
  logic [N-1:0] req;
  logic         in_valid, in_ready, rr_mode, out_any, out_valid, out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [N-1:0] req;
    logic         rr;
    logic [W-1:0] exp_idx;
    logic [N-1:0] exp_oh;
    logic         exp_any;
    logic [W-1:0] exp_ptr;
  } vec_t;

  vec_t vecs[$];

  prio_encoder_rr #(.N(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .rr_mode_i    (rr_mode),
    .out_idx_o    (out_idx),
    .out_onehot_o (out_onehot),
    .out_any_o    (out_any),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] idx, input logic [N-1:0] oh,
                         input logic any, input logic vld);
    chk({tag, ".idx"},    32'(out_idx),    32'(idx));
    chk({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
    chk({tag, ".any"},    32'(out_any),    32'(any));
    chk({tag, ".valid"},  32'(out_valid),  32'(vld));
  endtask

  task automatic add(input logic [N-1:0] r, input logic rr, input logic [W-1:0] idx,
                     input logic [N-1:0] oh, input logic any, input logic [W-1:0] p);
    vec_t v;
    v.req = r; v.rr = rr; v.exp_idx = idx; v.exp_oh = oh; v.exp_any = any; v.exp_ptr = p;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < N; i++) add(8'(1) << i, 1'b0, W'(i), 8'(1) << i, 1'b1, 3'd0);
    add(8'hA4, 1'b0, 3'd7, 8'h80, 1'b1, 3'd0);
    add(8'hA4, 1'b1, 3'd2, 8'h04, 1'b1, 3'd3);
    add(8'hA4, 1'b1, 3'd5, 8'h20, 1'b1, 3'd6);
    add(8'hA4, 1'b1, 3'd7, 8'h80, 1'b1, 3'd0);
    add(8'hA4, 1'b1, 3'd2, 8'h04, 1'b1, 3'd3);
    add(8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 3'd3);
    add(8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3);
    add(8'h20, 1'b1, 3'd5, 8'h20, 1'b1, 3'd6);
    add(8'h03, 1'b0, 3'd1, 8'h02, 1'b1, 3'd6);
    add(8'h03, 1'b1, 3'd0, 8'h01, 1'b1, 3'd1);
    add(8'h01, 1'b1, 3'd0, 8'h01, 1'b1, 3'd1);
    add(8'h80, 1'b1, 3'd7, 8'h80, 1'b1, 3'd0);

    // Reset held with a valid request pending
    rst = 1'b1; in_valid = 1'b1; req = 8'hFF; rr_mode = 1'b1; out_ready = 1'b1;
    #2;
    chk_out("rst_async", 3'd0, 8'h00, 1'b0, 1'b0);
    chk("rst_async.in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst_held", 3'd0, 8'h00, 1'b0, 1'b0);
    chk("rst_held.ptr", 32'(dut.ptr_q), 32'd0);
    rst = 1'b0;

    foreach (vecs[n]) begin
      req = vecs[n].req; rr_mode = vecs[n].rr; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", n), vecs[n].exp_idx, vecs[n].exp_oh, vecs[n].exp_any, 1'b1);
      chk($sformatf("vec%0d.ptr", n), 32'(dut.ptr_q), 32'(vecs[n].exp_ptr));
    end

    // Drain, then backpressure
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain.valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; rr_mode = 1'b0; req = 8'h10; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_out("bp_load", 3'd4, 8'h10, 1'b1, 1'b1);
    req = 8'h40;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_out($sformatf("bp_hold%0d", c), 3'd4, 8'h10, 1'b1, 1'b1);
      chk($sformatf("bp_hold%0d.in_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk_out("bp_next", 3'd6, 8'h40, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drain.valid", 32'(out_valid), 32'd0);
    chk("bp.ptr", 32'(dut.ptr_q), 32'd0);

    // Reset mid-stream discards the pending beat
    in_valid = 1'b1; rr_mode = 1'b1; req = 8'h04; out_ready = 1'b0;
    @(posedge clk); #1;
    chk_out("mid_load", 3'd2, 8'h04, 1'b1, 1'b1);
    chk("mid_load.ptr", 32'(dut.ptr_q), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_rst", 3'd0, 8'h00, 1'b0, 1'b0);
    chk("mid_rst.ptr", 32'(dut.ptr_q), 32'd0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; req = 8'hFF; out_ready = 1'b1;
    @(posedge clk); #1;
    chk_out("post_rst", 3'd0, 8'h01, 1'b1, 1'b1);
    chk("post_rst.ptr", 32'(dut.ptr_q), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised N-to-log2(N) encoder with a registered, handshaked output stage and two arbitration modes. Fixed-priority mode selects the highest set request bit. Round-robin mode rotates priority with a stored pointer, so multi-hot requests resolve fairly. The block sits between request sources (interrupt lines, requester masks) and downstream logic that consumes a one-cycle-latency grant index under valid/ready flow control.

## Interface
- `N`, default 8: number of request inputs; any value ≥ 2, not necessarily a power of two.
- `W`, default `$clog2(N)`: width of the index output; derived, never overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N: request vector, sampled on accept.
- `in_valid` in 1: `req` and `rr_mode` are valid this cycle.
- `in_ready` out 1: block can accept this cycle.
- `rr_mode` in 1: 0 = fixed priority (highest index wins); 1 = round-robin. Sampled with `req`.
- `out_idx` out W: winning index.
- `out_onehot` out N: one-hot of the winner; all zeros if there is no request.
- `out_any` out 1: at least one `req` bit was set in the accepted beat.
- `out_valid` out 1: output register holds an unconsumed beat.
- `out_ready` in 1: downstream accepts the beat.

## Operation
- Accept condition: `in_valid && in_ready`. Output is taken when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational, giving single-stage pipeline behaviour with full throughput.
- Fixed mode: the winner is the highest set bit of `req`. With exactly one bit set, `out_idx` equals that bit's index.
- Round-robin mode: the search starts at pointer `ptr` (W bits, range 0..N-1) and goes upward, wrapping N-1 → 0. The winner is the first set bit found.
- `ptr` update on an accepted beat with `rr_mode=1` and `req≠0`: `ptr ← (winner == N-1) ? 0 : winner+1`.
- `ptr` is unchanged in fixed mode, when `req==0`, and when there is no accept.
- `ptr` is retained across mode changes. A mode switch affects only the beat it is sampled with.
- `req==0` still produces an output beat: `out_any=0`, `out_idx=0`, `out_onehot=0`.
- Output register update:
  - On accept, load `out_idx`, `out_onehot` and `out_any`, and set `out_valid=1`.
  - Output taken with no new accept: clear `out_valid`. Data fields hold their value (don't-care).
  - Simultaneous take and accept: the new beat replaces the old one and `out_valid` stays 1.
- While `out_valid && !out_ready`, all outputs hold stable. `in_ready=0`, so no input is lost.
- `N` not a power of two: `ptr` and the winner never exceed N-1, and the wrap goes N-1 → 0.

## Timing
- Latency: 1 cycle. A beat accepted at edge k appears on the outputs after edge k.
- Throughput: 1 beat per cycle while `out_ready=1`.
- Reset, asynchronous and effective immediately: `ptr=0`, `out_valid=0`, `out_idx=0`, `out_onehot=0`, `out_any=0`.
  - `in_ready` therefore reads 1 during and after reset.
- Reset mid-stream: any pending output beat is discarded, not delivered. The first accept after reset deasserts searches from `ptr=0`.
- The winner search is purely combinational from `req`, `rr_mode` and `ptr`. It is a single stage with no internal pipelining.

## Test plan
All scenarios use N=8.
- Reset with `in_valid=1` asserted → outputs all 0, `out_valid=0`, `in_ready=1`. After release, the first accepted beat uses `ptr=0`.
- Fixed mode, one-hot sweep `req=1<<i` for i=0..7 with `out_ready=1` → `out_idx=i`, `out_any=1`, one beat per cycle, 1-cycle latency. Then `req=8'b1010_0100` → `out_idx=7`, `out_onehot=8'h80`.
- Round-robin, `req=8'b1010_0100` held for 4 beats → `out_idx` = 2, 5, 7, 2; `ptr` = 3, 6, 0, 3.
- `req=0` in both modes → `out_any=0`, `out_idx=0`, `out_onehot=0`, `out_valid=1`; `ptr` unchanged.
- Backpressure: `out_ready=0` for 3 cycles with `in_valid=1` → first beat holds stable and `in_ready=0`. Raise `out_ready` → the held beat is taken, the next beat loads in the same cycle, and no beat is dropped or duplicated.
- Mode switch: with RR `ptr=6`, send a fixed-mode beat `req=8'h03` → `out_idx=1`, `ptr` stays 6. Then an RR beat with `req=8'h03` → `out_idx=0`, `ptr=1`.
